// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller: load-use bubbles, taken-branch flushes,
// data-memory wait freezes with a watchdog. Optional perf counters: PIPE_PERF_CNT_EN.
module hazard_ctrl #(
  parameter int unsigned WAIT_MAX = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  ID_RSaddr_i,
  input  logic [4:0]  ID_RTaddr_i,
  input  logic        ID_usesRS_i,
  input  logic        ID_usesRT_i,
  input  logic        EX_MemRead_i,
  input  logic [4:0]  EX_RDaddr_i,
  input  logic        EX_BranchTaken_i,
  input  logic        MEM_req_i,
  input  logic        MEM_ack_i,
  output logic        PC_Write_o,
  output logic        IF_ID_Write_o,
  output logic        IF_ID_Flush_o,
  output logic        ID_EX_Write_o,
  output logic        ID_EX_Bubble_o,
  output logic        EX_MEM_Write_o,
  output logic        MEM_WB_Bubble_o,
  output logic        halt_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [7:0] WCNT_LAST = 8'(WAIT_MAX - 1);

  state_t     state_q, state_d;
  logic [7:0] wcnt_q, wcnt_d;
  logic       load_use;
  logic       freeze;
  logic       resolve;

  assign load_use = EX_MemRead_i && (EX_RDaddr_i != 5'd0) &&
                    ((ID_usesRS_i && (ID_RSaddr_i == EX_RDaddr_i)) ||
                     (ID_usesRT_i && (ID_RTaddr_i == EX_RDaddr_i)));

  assign halt_o = (state_q == HALT);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RUN;
      wcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wcnt_d          = wcnt_q;
    freeze          = 1'b0;
    resolve         = 1'b0;
    PC_Write_o      = 1'b1;
    IF_ID_Write_o   = 1'b1;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Write_o   = 1'b1;
    ID_EX_Bubble_o  = 1'b0;
    EX_MEM_Write_o  = 1'b1;
    MEM_WB_Bubble_o = 1'b0;

    case (state_q)
      RUN: begin
        if (MEM_req_i && !MEM_ack_i) begin
          freeze  = 1'b1;
          state_d = MEM_WAIT;
          wcnt_d  = 8'd1;
        end else begin
          resolve = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!MEM_ack_i) begin
          freeze = 1'b1;
          if (wcnt_q == WCNT_LAST) state_d = HALT;
          else                     wcnt_d  = wcnt_q + 8'd1;
        end else begin
          // Release cycle: the held EX/ID instructions are re-examined now.
          resolve = 1'b1;
          state_d = RUN;
          wcnt_d  = 8'd0;
        end
      end
      HALT: begin
        PC_Write_o     = 1'b0;
        IF_ID_Write_o  = 1'b0;
        ID_EX_Write_o  = 1'b0;
        EX_MEM_Write_o = 1'b0;
      end
      default: state_d = RUN;
    endcase

    if (freeze) begin
      PC_Write_o      = 1'b0;
      IF_ID_Write_o   = 1'b0;
      ID_EX_Write_o   = 1'b0;
      EX_MEM_Write_o  = 1'b0;
      MEM_WB_Bubble_o = 1'b1;
    end else if (resolve && EX_BranchTaken_i) begin
      IF_ID_Flush_o  = 1'b1;
      ID_EX_Bubble_o = 1'b1;
    end else if (resolve && load_use) begin
      PC_Write_o     = 1'b0;
      IF_ID_Write_o  = 1'b0;
      ID_EX_Bubble_o = 1'b1;
    end

    // Reset loads NOPs everywhere regardless of state.
    if (rst_i) begin
      PC_Write_o      = 1'b1;
      IF_ID_Write_o   = 1'b1;
      IF_ID_Flush_o   = 1'b1;
      ID_EX_Write_o   = 1'b1;
      ID_EX_Bubble_o  = 1'b1;
      EX_MEM_Write_o  = 1'b1;
      MEM_WB_Bubble_o = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic        branch_fire;

  // Flush is only raised by a taken branch outside reset.
  assign branch_fire = IF_ID_Flush_o && !rst_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (!PC_Write_o && (stall_cnt_q != 32'hFFFF_FFFF))
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (branch_fire && (flush_cnt_q != 32'hFFFF_FFFF))
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`else
  assign stall_cnt_o = 32'd0;
  assign flush_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected
// control/counter values; a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic        uses_rs, uses_rt, mem_read, br_taken, mem_req, mem_ack;
  logic        pc_w, ifid_w, ifid_fl, idex_w, idex_bub, exmem_w, memwb_bub, halt;
  logic [31:0] stall_cnt, flush_cnt;

  // ctrl bits: pc_w ifid_w ifid_fl idex_w idex_bub exmem_w memwb_bub halt
  localparam logic [7:0] C_NORM  = 8'b1101_0100;
  localparam logic [7:0] C_RST   = 8'b1111_1110;
  localparam logic [7:0] C_RSTH  = 8'b1111_1111;
  localparam logic [7:0] C_LU    = 8'b0001_1100;
  localparam logic [7:0] C_BR    = 8'b1111_1100;
  localparam logic [7:0] C_FRZ   = 8'b0000_0010;
  localparam logic [7:0] C_HLT   = 8'b0000_0001;

  logic [71:0] exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int n_cycle  = 0;

  hazard_ctrl #(.WAIT_MAX(4)) dut (
    .clk_i(clk), .rst_i(rst),
    .ID_RSaddr_i(rs_addr), .ID_RTaddr_i(rt_addr),
    .ID_usesRS_i(uses_rs), .ID_usesRT_i(uses_rt),
    .EX_MemRead_i(mem_read), .EX_RDaddr_i(rd_addr),
    .EX_BranchTaken_i(br_taken),
    .MEM_req_i(mem_req), .MEM_ack_i(mem_ack),
    .PC_Write_o(pc_w), .IF_ID_Write_o(ifid_w), .IF_ID_Flush_o(ifid_fl),
    .ID_EX_Write_o(idex_w), .ID_EX_Bubble_o(idex_bub),
    .EX_MEM_Write_o(exmem_w), .MEM_WB_Bubble_o(memwb_bub),
    .halt_o(halt), .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [31:0] cnt_exp(input int v);
`ifdef PIPE_PERF_CNT_EN
    return 32'(v);
`else
    return 32'd0;
`endif
  endfunction

  // driver: one call = one clock cycle of inputs plus its expected response
  task automatic cyc(input logic r, input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt, input logic mr,
                     input logic [4:0] rd, input logic br, input logic req,
                     input logic ack, input logic [7:0] ec, input int es,
                     input int ef);
    @(posedge clk);
    #1;
    rst = r; rs_addr = rs; rt_addr = rt; uses_rs = urs; uses_rt = urt;
    mem_read = mr; rd_addr = rd; br_taken = br; mem_req = req; mem_ack = ack;
    exp_q.push_back({ec, cnt_exp(es), cnt_exp(ef)});
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [71:0] e;
      logic [7:0]  act_ctrl;
      e = exp_q.pop_front();
      n_cycle++;
      act_ctrl = {pc_w, ifid_w, ifid_fl, idex_w, idex_bub, exmem_w, memwb_bub, halt};
      n_checks++;
      if (act_ctrl !== e[71:64]) begin
        n_fail++;
        $display("FAIL ctrl step %0d: got %b expected %b", n_cycle, act_ctrl, e[71:64]);
      end
      n_checks++;
      if (stall_cnt !== e[63:32]) begin
        n_fail++;
        $display("FAIL stall_cnt step %0d: got %0d expected %0d", n_cycle, stall_cnt, e[63:32]);
      end
      n_checks++;
      if (flush_cnt !== e[31:0]) begin
        n_fail++;
        $display("FAIL flush_cnt step %0d: got %0d expected %0d", n_cycle, flush_cnt, e[31:0]);
      end
    end
  end

  initial begin
    rst = 1'b1; rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
    uses_rs = 1'b0; uses_rt = 1'b0; mem_read = 1'b0; br_taken = 1'b0;
    mem_req = 1'b0; mem_ack = 1'b0;

    //   rst rs     rt     urs   urt   mr    rd     br    req   ack   ctrl    st fl
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RST,  0, 0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 0, 0);
    // load-use on rs1, then normal flow
    cyc(1'b0, 5'd5, 5'd3, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU,   0, 0);
    cyc(1'b0, 5'd5, 5'd3, 1'b1, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0, C_NORM, 1, 0);
    // load-use on rs2; same addresses with rs2 unused; rd = x0; not a load
    cyc(1'b0, 5'd1, 5'd7, 1'b1, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU,   1, 0);
    cyc(1'b0, 5'd1, 5'd7, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_NORM, 2, 0);
    cyc(1'b0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2, 0);
    cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_NORM, 2, 0);
    // branch beats load-use
    cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_BR,   2, 0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 2, 1);
    // same-cycle ack never freezes
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NORM, 2, 1);
    // memory wait: three frozen cycles then release
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  2, 1);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  3, 1);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  4, 1);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, C_NORM, 5, 1);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 5, 1);
    // branch pending during freeze flushes on the ack cycle
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_FRZ,  5, 1);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0, C_FRZ,  6, 1);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_BR,   7, 1);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 7, 2);
    // watchdog with WAIT_MAX = 4
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  7, 2);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  8, 2);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  9, 2);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ, 10, 2);
    cyc(1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, C_HLT, 11, 2);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_HLT, 12, 2);
    // reset out of HALT
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_RSTH, 13, 2);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 0, 0);
    // reset mid-wait
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_FRZ,  0, 0);
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, C_RST,  1, 0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 0, 0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1, C_BR,   0, 0);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_NORM, 0, 1);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
